crash_monitor: RTL
==================

// Module: crash_monitor
// PURPOSE
//  Game-state stage downstream of traffic. Pixel-wise compares traffic's is_car
//  against the red/blue player-car masks during scan-out, accumulates overlap per
//  frame, and declares a crash at frame boundary. Owns IDLE/PLAY/CRASH/OVER FSM,
//  lives and score; drives freeze to stall traffic/player motion.
// PARAMETERS
//  HIT_THRESH    4      overlap pixels per frame needed to declare a crash
//  CRASH_FRAMES  60     frames held in CRASH before resuming/ending
//  LIVES         3      lives loaded in IDLE (must be 1..3)
//  SCORE_DIV     30     PLAY frames per score increment
//  START_KEY     8'h2C  keycode that starts/restarts (space)
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   synchronous, active-low reset
//  frame_clk    in   1   frame strobe (vsync-derived), sampled on Clk
//  DrawX        in   10  current pixel column
//  DrawY        in   10  current pixel row
//  is_car       in   1   pixel belongs to a yellow car (from traffic)
//  is_redcar    in   1   pixel belongs to red player car
//  is_bluecar   in   1   pixel belongs to blue player car
//  keycode      in   8   current keyboard code
//  game_state   out  2   0 IDLE, 1 PLAY, 2 CRASH, 3 OVER
//  crash_pulse  out  1   one-Clk pulse when crash declared
//  freeze       out  1   1 = motion halted (all states except PLAY)
//  lives        out  2   remaining lives
//  score        out  16  frames-survived score
// BEHAVIOUR
//  Clocking: one clock Clk; reset synchronous, active-low. All regs load reset values
//   on the first Clk edge with Reset=0, including mid-game.
//  Reset values: game_state=0, crash_pulse=0, freeze=1, lives=LIVES, score=0,
//   internal counters 0, frame_clk_d=0, key_d=0.
//  frame_tick = frame_clk & ~frame_clk_d (rising edge, one Clk wide).
//  key_hit = (keycode==START_KEY) & ~key_d; held key gives exactly one key_hit.
//  Stage 1 (latency 1): hit_r <= is_car & (is_redcar|is_bluecar) & DrawX<640 & DrawY<480.
//  Stage 2: hit_cnt (8b) += hit_r, saturates at 255; counts only in PLAY, else 0.
//   On frame_tick: crash_cond = (hit_cnt >= HIT_THRESH); hit_cnt cleared to 0;
//   hit_r arriving in the frame_tick cycle is discarded.
//  FSM (transitions take effect the Clk after the condition):
//   IDLE : freeze=1; lives<=LIVES; score<=0; key_hit -> PLAY.
//   PLAY : freeze=0; on frame_tick:
//          crash_cond -> CRASH, crash_pulse=1 for 1 Clk, lives<=lives-1, crash_ctr<=0;
//          else div_ctr++, at SCORE_DIV-1 div_ctr<=0 and score++ (saturate FFFF).
//          Crash and score tick on same frame_tick: crash wins, no increment.
//   CRASH: freeze=1; score/div_ctr held; frame_tick increments crash_ctr;
//          frame_tick with crash_ctr==CRASH_FRAMES-1 -> OVER if lives==0, else PLAY.
//   OVER : freeze=1; score held; key_hit -> IDLE.
//  keycode ignored in PLAY and CRASH. lives never underflows (CRASH only from lives>=1).
//  crash_pulse is 0 in every cycle not named above.
// TESTING
//  1 Reset=0 two Clk mid-PLAY -> game_state=0, freeze=1, lives=3, score=0, crash_pulse=0.
//  2 IDLE, keycode=8'h2C held 20 Clk -> PLAY after 1 Clk, freeze=0, no further transition.
//  3 PLAY, 3 overlap pixels then frame_tick -> stays PLAY; 4 pixels -> crash_pulse 1 Clk,
//    lives=2, state CRASH; overlap at DrawX=700 -> not counted.
//  4 CRASH with lives=2, 60 frame_ticks -> PLAY on 60th; score unchanged throughout.
//  5 PLAY, 90 clean frame_ticks -> score=3; crash on 30th frame of a group -> no increment.
//  6 Third crash + 60 frames -> OVER, score held; key press/release/press -> IDLE then PLAY,
//    lives=3, score=0.

Source files
------------

// File: rtl/crash_monitor.sv
// crash_monitor: game-state stage behind the traffic renderer.
// Counts yellow-car / player-car pixel overlap per frame during scan-out,
// declares a crash at the frame boundary, and owns the game FSM, lives and score.
module crash_monitor #(
    parameter int unsigned HIT_THRESH   = 4,
    parameter int unsigned CRASH_FRAMES = 60,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_DIV    = 30,
    parameter logic [7:0]  START_KEY    = 8'h2C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        is_car,
    input  logic        is_redcar,
    input  logic        is_bluecar,
    input  logic [7:0]  keycode,
    output logic [1:0]  game_state,
    output logic        crash_pulse,
    output logic        freeze,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    localparam int unsigned CW = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
    localparam int unsigned DW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [CW-1:0] CRASH_LAST = CW'(CRASH_FRAMES - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SCORE_DIV - 1);
    localparam logic [7:0]    THRESH     = 8'(HIT_THRESH);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CRASH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t          state_q;
    logic            frame_clk_q;
    logic            key_q;
    logic            hit_q;
    logic [7:0]      hit_cnt_q;
    logic            crash_pulse_q;
    logic            freeze_q;
    logic [1:0]      lives_q;
    logic [15:0]     score_q;
    logic [DW-1:0]   div_ctr_q;
    logic [CW-1:0]   crash_ctr_q;

    logic            frame_tick;
    logic            key_match;
    logic            key_hit;
    logic            hit_d;
    logic            crash_cond;

    assign frame_tick = frame_clk & ~frame_clk_q;
    assign key_match  = (keycode == START_KEY);
    assign key_hit    = key_match & ~key_q;
    assign hit_d      = is_car & (is_redcar | is_bluecar) & (DrawX < 10'd640) & (DrawY < 10'd480);
    assign crash_cond = (hit_cnt_q >= THRESH);

    // Edge detectors for frame strobe and start key, plus the registered overlap pixel.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            frame_clk_q <= 1'b0;
            key_q       <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            key_q       <= key_match;
            hit_q       <= hit_d;
        end
    end

    // Per-frame overlap accumulator; a hit landing on the frame_tick cycle is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset || state_q != S_PLAY || frame_tick) begin
            hit_cnt_q <= '0;
        end else if (hit_q && hit_cnt_q != '1) begin
            hit_cnt_q <= hit_cnt_q + 8'd1;
        end
    end

    // Game FSM with registered freeze/crash_pulse, lives and score bookkeeping.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            crash_pulse_q <= 1'b0;
            freeze_q      <= 1'b1;
            lives_q       <= LIVES_INIT;
            score_q       <= '0;
            div_ctr_q     <= '0;
            crash_ctr_q   <= '0;
        end else begin
            crash_pulse_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    freeze_q    <= 1'b1;
                    lives_q     <= LIVES_INIT;
                    score_q     <= '0;
                    div_ctr_q   <= '0;
                    crash_ctr_q <= '0;
                    if (key_hit) begin
                        state_q  <= S_PLAY;
                        freeze_q <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (frame_tick) begin
                        if (crash_cond) begin
                            state_q       <= S_CRASH;
                            freeze_q      <= 1'b1;
                            crash_pulse_q <= 1'b1;
                            lives_q       <= lives_q - 2'd1;
                            crash_ctr_q   <= '0;
                        end else if (div_ctr_q == DIV_LAST) begin
                            div_ctr_q <= '0;
                            if (score_q != '1) begin
                                score_q <= score_q + 16'd1;
                            end
                        end else begin
                            div_ctr_q <= div_ctr_q + 1'b1;
                        end
                    end
                end
                S_CRASH: begin
                    if (frame_tick) begin
                        if (crash_ctr_q == CRASH_LAST) begin
                            crash_ctr_q <= '0;
                            if (lives_q == 2'd0) begin
                                state_q <= S_OVER;
                            end else begin
                                state_q  <= S_PLAY;
                                freeze_q <= 1'b0;
                            end
                        end else begin
                            crash_ctr_q <= crash_ctr_q + 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (key_hit) begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign game_state  = state_q;
    assign crash_pulse = crash_pulse_q;
    assign freeze      = freeze_q;
    assign lives       = lives_q;
    assign score       = score_q;

endmodule
